// File: rtl/decode_issue_reg_pkg.sv
// Shared types for the decode-to-execute issue register: operand words,
// register addresses, the issued packet and the interlock state.
package decode_issue_reg_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CREG_W = 5;
    localparam int unsigned CTRL_W = 8;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [CREG_W-1:0] creg_addr_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        word_t      pc;
        ctrl_t      ctrl;
        creg_addr_t src1;
        creg_addr_t src2;
        word_t      vr1;
        word_t      vr2;
        creg_addr_t dst;
        logic       is_load;
    } issue_pkt_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/decode_issue_reg_loaduse_detect.sv
// Load-use compare between the E-stage load and the decode consumer.
// A zero destination never matches, so $0 sources never stall.
module decode_issue_reg_loaduse_detect
    import decode_issue_reg_pkg::*;
(
    input  logic       e_valid_i,
    input  logic       e_is_load_i,
    input  creg_addr_t e_dst_i,
    input  logic       d_valid_i,
    input  creg_addr_t d_src1_i,
    input  creg_addr_t d_src2_i,
    output logic       hazard_c
);

    logic src_match_c;

    assign src_match_c = (d_src1_i == e_dst_i) || (d_src2_i == e_dst_i);
    assign hazard_c    = e_valid_i && e_is_load_i && (e_dst_i != '0) &&
                         d_valid_i && src_match_c;

endmodule

// File: rtl/decode_issue_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// execute back-pressure, flush and a saturating bubble counter.
module decode_issue_reg
    import decode_issue_reg_pkg::*;
#(
    parameter int unsigned LOADUSE_BUBBLES = 1,
    parameter int unsigned PERF_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              d_valid,
    input  issue_pkt_t        d_pkt,
    output logic              d_ready,
    input  logic              e_ready,
    output logic              e_valid,
    output issue_pkt_t        e_pkt,
    output logic [PERF_W-1:0] bubble_cnt
);

    localparam int unsigned LEFT_W = 2;

    issue_state_t      state_q;
    logic [LEFT_W-1:0] left_q;
    logic              e_valid_q;
    issue_pkt_t        e_pkt_q;
    logic [PERF_W-1:0] perf_q;
    logic [PERF_W-1:0] perf_d;

    logic hazard_raw_c;
    logic hazard_c;
    logic adv_c;

    decode_issue_reg_loaduse_detect u_loaduse_detect (
        .e_valid_i   (e_valid_q),
        .e_is_load_i (e_pkt_q.is_load),
        .e_dst_i     (e_pkt_q.dst),
        .d_valid_i   (d_valid),
        .d_src1_i    (d_pkt.src1),
        .d_src2_i    (d_pkt.src2),
        .hazard_c    (hazard_raw_c)
    );

    assign hazard_c = (state_q == RUN) && hazard_raw_c;
    assign adv_c    = !e_valid_q || e_ready;
    assign d_ready  = (state_q == RUN) && adv_c && !hazard_c && !flush;

    // Bubble counter sticks at all-ones instead of wrapping
    assign perf_d = (&perf_q) ? perf_q : perf_q + PERF_W'(1);

    // Interlock state, E-stage slot and perf counter; flush outranks a stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RUN;
            left_q    <= '0;
            e_valid_q <= 1'b0;
            e_pkt_q   <= '0;
            perf_q    <= '0;
        end else if (flush) begin
            state_q   <= RUN;
            left_q    <= '0;
            e_valid_q <= 1'b0;
        end else if (adv_c) begin
            if (state_q == BUBBLE) begin
                e_valid_q <= 1'b0;
                perf_q    <= perf_d;
                left_q    <= left_q - LEFT_W'(1);
                if (left_q == LEFT_W'(1)) begin
                    state_q <= RUN;
                end
            end else if (hazard_c) begin
                e_valid_q <= 1'b0;
                perf_q    <= perf_d;
                if (LOADUSE_BUBBLES > 1) begin
                    state_q <= BUBBLE;
                    left_q  <= LEFT_W'(LOADUSE_BUBBLES - 1);
                end
            end else begin
                e_valid_q <= d_valid;
                if (d_valid) begin
                    e_pkt_q <= d_pkt;
                end
            end
        end
    end

    assign e_valid    = e_valid_q;
    assign e_pkt      = e_pkt_q;
    assign bubble_cnt = perf_q;

endmodule

// File: tb/tb_decode_issue_reg.sv
// Bench for decode_issue_reg: two instances (1 and 3 bubbles, the second with
// a narrow counter) checked every cycle against an owed-bubble reference model.
module tb_decode_issue_reg;
    import decode_issue_reg_pkg::*;

    localparam int unsigned PW0 = 32;
    localparam int unsigned PW1 = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic              flush0, d_valid0, e_ready0, d_ready0, e_valid0;
    issue_pkt_t        d_pkt0, e_pkt0;
    logic [PW0-1:0]    bc0;
    logic              flush1, d_valid1, e_ready1, d_ready1, e_valid1;
    issue_pkt_t        d_pkt1, e_pkt1;
    logic [PW1-1:0]    bc1;

    // stimulus per instance
    logic       s_dv[2];
    logic       s_fl[2];
    logic       s_er[2];
    issue_pkt_t s_pkt[2];

    assign d_valid0 = s_dv[0];
    assign flush0   = s_fl[0];
    assign e_ready0 = s_er[0];
    assign d_pkt0   = s_pkt[0];
    assign d_valid1 = s_dv[1];
    assign flush1   = s_fl[1];
    assign e_ready1 = s_er[1];
    assign d_pkt1   = s_pkt[1];

    decode_issue_reg #(.LOADUSE_BUBBLES(1), .PERF_W(PW0)) u_dut0 (
        .clk(clk), .resetn(resetn), .flush(flush0), .d_valid(d_valid0),
        .d_pkt(d_pkt0), .d_ready(d_ready0), .e_ready(e_ready0),
        .e_valid(e_valid0), .e_pkt(e_pkt0), .bubble_cnt(bc0)
    );

    decode_issue_reg #(.LOADUSE_BUBBLES(3), .PERF_W(PW1)) u_dut1 (
        .clk(clk), .resetn(resetn), .flush(flush1), .d_valid(d_valid1),
        .d_pkt(d_pkt1), .d_ready(d_ready1), .e_ready(e_ready1),
        .e_valid(e_valid1), .e_pkt(e_pkt1), .bubble_cnt(bc1)
    );

    // reference model: what sits in E, bubbles still owed, bubbles counted
    int              lb[2];
    longint unsigned sat[2];
    logic            m_ev[2];
    issue_pkt_t      m_pkt[2];
    longint unsigned m_cnt[2];
    int              m_owed[2];

    int errors = 0;
    int checks = 0;

    function automatic logic get_dr(input int i);
        return (i == 0) ? d_ready0 : d_ready1;
    endfunction

    function automatic logic get_ev(input int i);
        return (i == 0) ? e_valid0 : e_valid1;
    endfunction

    function automatic issue_pkt_t get_pkt(input int i);
        return (i == 0) ? e_pkt0 : e_pkt1;
    endfunction

    function automatic longint unsigned get_bc(input int i);
        return (i == 0) ? 64'(bc0) : 64'(bc1);
    endfunction

    function automatic logic m_hazard(input int i);
        return (m_owed[i] == 0) && m_ev[i] && m_pkt[i].is_load &&
               (m_pkt[i].dst != 0) && s_dv[i] &&
               ((s_pkt[i].src1 == m_pkt[i].dst) || (s_pkt[i].src2 == m_pkt[i].dst));
    endfunction

    function automatic logic m_dready(input int i);
        return (m_owed[i] == 0) && (!m_ev[i] || s_er[i]) && !m_hazard(i) && !s_fl[i];
    endfunction

    task automatic bump(input int i);
        if (m_cnt[i] < sat[i]) m_cnt[i] = m_cnt[i] + 1;
    endtask

    task automatic m_edge(input int i);
        logic hz;
        logic adv;
        hz  = m_hazard(i);
        adv = !m_ev[i] || s_er[i];
        if (s_fl[i]) begin
            m_ev[i]   = 1'b0;
            m_owed[i] = 0;
        end else if (adv) begin
            if (m_owed[i] > 0) begin
                m_ev[i] = 1'b0;
                bump(i);
                m_owed[i] = m_owed[i] - 1;
            end else if (hz) begin
                m_ev[i] = 1'b0;
                bump(i);
                m_owed[i] = lb[i] - 1;
            end else begin
                m_ev[i] = s_dv[i];
                if (s_dv[i]) m_pkt[i] = s_pkt[i];
            end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_ev[i]   = 1'b0;
            m_pkt[i]  = '0;
            m_cnt[i]  = 0;
            m_owed[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: check d_ready, advance model, check registered outputs
    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("d_ready%0d", i), 128'(get_dr(i)), 128'(m_dready(i)));
        for (int i = 0; i < 2; i++) m_edge(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("e_valid%0d", i), 128'(get_ev(i)), 128'(m_ev[i]));
            chk($sformatf("bubble_cnt%0d", i), 128'(get_bc(i)), 128'(m_cnt[i]));
            if (m_ev[i])
                chk($sformatf("e_pkt%0d", i), 128'(get_pkt(i)), 128'(m_pkt[i]));
        end
    endtask

    function automatic issue_pkt_t mk(input word_t pc, input int s1, input int s2,
                                      input int d, input logic ld,
                                      input word_t v1, input word_t v2);
        issue_pkt_t p;
        p.pc      = pc;
        p.ctrl    = ctrl_t'(pc);
        p.src1    = creg_addr_t'(s1);
        p.src2    = creg_addr_t'(s2);
        p.vr1     = v1;
        p.vr2     = v2;
        p.dst     = creg_addr_t'(d);
        p.is_load = ld;
        return p;
    endfunction

    task automatic drive(input int i, input logic dv, input issue_pkt_t p);
        s_dv[i]  = dv;
        s_pkt[i] = p;
        s_fl[i]  = 1'b0;
        s_er[i]  = 1'b1;
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, '0);
    endtask

    initial begin
        lb[0]  = 1;
        lb[1]  = 3;
        sat[0] = (64'd1 << PW0) - 1;
        sat[1] = (64'd1 << PW1) - 1;
        m_reset();
        idle(0);
        idle(1);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_e_valid0", 128'(e_valid0), 128'(0));
        chk("rst_bc0", 128'(bc0), 128'(0));
        chk("rst_d_ready0", 128'(d_ready0), 128'(1));
        chk("rst_e_valid1", 128'(e_valid1), 128'(0));
        chk("rst_bc1", 128'(bc1), 128'(0));

        // back-to-back ALU ops with a register dependency
        drive(0, 1'b1, mk(32'h1000, 1, 2, 3, 1'b0, 32'h11, 32'h12)); cycle();
        chk("b2b_a", 128'(e_valid0), 128'(1));
        drive(0, 1'b1, mk(32'h1004, 3, 4, 6, 1'b0, 32'h21, 32'h22)); cycle();
        chk("b2b_b", 128'(e_pkt0.pc), 128'(32'h1004));
        drive(0, 1'b1, mk(32'h1008, 6, 1, 8, 1'b0, 32'h31, 32'h32)); cycle();
        chk("b2b_c", 128'(e_valid0), 128'(1));
        chk("b2b_bc", 128'(bc0), 128'(0));

        // load to $0 followed by a $0 reader: no interlock
        drive(0, 1'b1, mk(32'h2000, 1, 0, 0, 1'b1, 32'h0, 32'h0)); cycle();
        drive(0, 1'b1, mk(32'h2004, 0, 2, 9, 1'b0, 32'h5, 32'h6)); cycle();
        chk("zero_issue", 128'(e_pkt0.pc), 128'(32'h2004));
        chk("zero_bc", 128'(bc0), 128'(0));

        // load-use with one bubble; vr2 is re-forwarded during the stall
        drive(0, 1'b1, mk(32'h3000, 1, 0, 5, 1'b1, 32'h0, 32'h0)); cycle();
        drive(0, 1'b1, mk(32'h3004, 2, 5, 10, 1'b0, 32'h7, 32'h1111)); cycle();
        chk("lu_bubble", 128'(e_valid0), 128'(0));
        chk("lu_bc", 128'(bc0), 128'(1));
        drive(0, 1'b1, mk(32'h3004, 2, 5, 10, 1'b0, 32'h7, 32'h2222)); cycle();
        chk("lu_issue", 128'(e_valid0), 128'(1));
        chk("lu_vr2", 128'(e_pkt0.vr2), 128'(32'h2222));

        // execute back-pressure holding a load with a waiting consumer
        drive(0, 1'b1, mk(32'h4000, 1, 0, 7, 1'b1, 32'h0, 32'h0)); cycle();
        drive(0, 1'b1, mk(32'h4004, 7, 2, 11, 1'b0, 32'h44, 32'h45));
        s_er[0] = 1'b0;
        repeat (4) begin
            cycle();
            chk("bp_hold", 128'(e_pkt0.pc), 128'(32'h4000));
            chk("bp_bc", 128'(bc0), 128'(1));
        end
        s_er[0] = 1'b1; cycle();
        chk("bp_bubble", 128'(e_valid0), 128'(0));
        cycle();
        chk("bp_issue", 128'(e_pkt0.pc), 128'(32'h4004));
        chk("bp_bc2", 128'(bc0), 128'(2));
        idle(0);

        // three-bubble load-use, flushed in the second bubble
        drive(1, 1'b1, mk(32'h5000, 1, 0, 9, 1'b1, 32'h0, 32'h0)); cycle();
        drive(1, 1'b1, mk(32'h5004, 3, 9, 12, 1'b0, 32'h1, 32'h2)); cycle();
        cycle();
        drive(1, 1'b1, mk(32'hBFC00380, 0, 0, 26, 1'b0, 32'h3, 32'h4));
        s_fl[1] = 1'b1; cycle();
        chk("fl_e_valid", 128'(e_valid1), 128'(0));
        s_fl[1] = 1'b0;
        #1;
        chk("fl_d_ready", 128'(d_ready1), 128'(1));
        cycle();
        chk("fl_issue", 128'(e_pkt1.pc), 128'(32'hBFC00380));
        chk("fl_bc", 128'(bc1), 128'(2));

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                s_dv[i]  = ($urandom_range(0, 3) != 0);
                s_fl[i]  = ($urandom_range(0, 19) == 0);
                s_er[i]  = ($urandom_range(0, 9) < 7);
                s_pkt[i] = mk(word_t'($urandom), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), word_t'($urandom), word_t'($urandom));
            end
            cycle();
        end

        // asynchronous reset while instance 1 is inside a bubble sequence
        s_fl[0] = 1'b1; s_fl[1] = 1'b1; cycle();
        idle(0); idle(1);
        drive(1, 1'b1, mk(32'h6000, 1, 0, 4, 1'b1, 32'h0, 32'h0)); cycle();
        drive(0, 1'b1, mk(32'h6100, 1, 2, 3, 1'b0, 32'h9, 32'h9));
        drive(1, 1'b1, mk(32'h6004, 4, 1, 13, 1'b0, 32'h8, 32'h8)); cycle();
        chk("ar_pre_bubble", 128'(e_valid1), 128'(0));
        chk("ar_pre_valid0", 128'(e_valid0), 128'(1));
        #2;
        resetn = 1'b0;
        #1;
        m_reset();
        chk("ar_e_valid0", 128'(e_valid0), 128'(0));
        chk("ar_e_valid1", 128'(e_valid1), 128'(0));
        chk("ar_bc0", 128'(bc0), 128'(0));
        chk("ar_bc1", 128'(bc1), 128'(0));
        idle(0); idle(1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_d_ready1", 128'(d_ready1), 128'(1));
        drive(1, 1'b1, mk(32'h7000, 4, 4, 14, 1'b0, 32'h1, 32'h1)); cycle();
        chk("ar_issue", 128'(e_pkt1.pc), 128'(32'h7000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_reg.md
Name: decode_issue_reg

Overview:
- Decode-to-execute pipeline register and issue interlock.
- Sits directly downstream of the decode forwarding muxes and captures the fully forwarded operand values; its registered output is the E-stage input.
- Inserts load-use bubbles. An E-stage load's value is never forwarded, so a dependent consumer must wait until the load reaches M.
- Honours execute back-pressure (multicycle mul/div) and flush (branch/exception).

Parameters:
- LOADUSE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- PERF_W, 32, width of the saturating bubble counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill the E-stage slot and any pending bubble
- d_valid  in  1  decode has an instruction
- d_pkt  in  issue_pkt_t  pc, ctrl, src1, src2, vr1, vr2 (forwarded), dst, is_load
- d_ready  out  1  packet accepted this cycle when d_valid && d_ready
- e_ready  in  1  execute can accept its current packet this cycle
- e_valid  out  1  E-stage slot holds a real instruction
- e_pkt  out  issue_pkt_t  registered packet driven to execute
- bubble_cnt  out  PERF_W  count of interlock bubbles inserted (saturating)

Behaviour:
- Reset (resetn low, asynchronous): e_valid=0, e_pkt=0, bubble_cnt=0, state=RUN, bubble counter=0. d_ready is then the combinational value for the RUN state with e_valid=0, which is 1.
- States: RUN, BUBBLE.
- Hazard (combinational, RUN only), all of the following true:
  - e_valid && e_pkt.is_load && e_pkt.dst!=0 && d_valid
  - d_pkt.src1==e_pkt.dst or d_pkt.src2==e_pkt.dst
  - a src equal to 0 never matches
- Advance: adv = !e_valid || e_ready.
- d_ready = (state==RUN) && adv && !hazard && !flush.
- Priority per clock edge, highest first:
  - flush:
    - e_valid<=0; state<=RUN; counter<=0.
    - Any d_valid packet presented in the same cycle is not accepted (d_ready=0).
  - !adv: hold e_valid/e_pkt unchanged; state and counter frozen.
  - RUN && hazard && adv:
    - e_valid<=0 (the load moves on, bubble enters E); bubble_cnt+=1.
    - If LOADUSE_BUBBLES>1: state<=BUBBLE, counter<=LOADUSE_BUBBLES-1. Otherwise stay in RUN.
  - BUBBLE && adv:
    - e_valid<=0; bubble_cnt+=1; counter-=1.
    - When the counter reaches 1 before decrement, state<=RUN.
  - RUN && adv && !hazard:
    - e_valid<=d_valid; e_pkt<=d_pkt when d_valid.
    - When !d_valid, e_pkt holds (don't-care contents).
- Latency: accepted packet appears on e_pkt the cycle after acceptance. With no stalls the throughput is one per cycle.
- Load-use penalty: exactly LOADUSE_BUBBLES cycles in which e_valid=0. The consumer is issued on the following cycle, using vr values resampled from decode.
- Operand values are captured only on acceptance. While d_ready=0, decode re-forwards every cycle.
- bubble_cnt saturates at all-ones and never wraps. It is not cleared by flush.
- Bubbles inserted while e_ready=0 are deferred: no count, no state change until adv.
- e_pkt fields are don't-care when e_valid=0; the bench checks only valid-qualified output.

Decomposition:
- mycpu package additions:
  - issue_pkt_t (packed struct, fields as in d_pkt; vr1/vr2 word_t; src/dst creg_addr_t)
  - issue_state_t enum {RUN, BUBBLE}
- Reuse the existing word_t and creg_addr_t.
- One natural sub-module: loaduse_detect, combinational hazard compare. The other three parts stay inline: the state register, the bubble counter and the perf counter.

Test Plan:
- Back-to-back ALU ops, e_ready=1:
  - A(dst=3), B(src1=3), C.
  - Expect e_valid=1 on three consecutive cycles, d_ready held 1, bubble_cnt=0.
- Load-use, LOADUSE_BUBBLES=1:
  - lw dst=5 issued, next add src2=5.
  - Expect one cycle with e_valid=0 and d_ready=0, then add issued with its vr2 updated; bubble_cnt=1.
- $0 destination: lw dst=0 followed by add src1=0 -> no bubble; add issues the next cycle; bubble_cnt stays 0.
- Execute back-pressure:
  - e_ready=0 for 4 cycles while lw dst=7 is in E and a consumer of r7 waits.
  - Expect e_pkt stable, d_ready=0, bubble_cnt unchanged.
  - After e_ready=1: one bubble, then the consumer issues; bubble_cnt=1.
- Flush during bubble:
  - LOADUSE_BUBBLES=3, flush asserted in the second bubble cycle.
  - Next cycle: state=RUN, e_valid=0, d_ready=1; a fresh packet (pc=0xBFC00380) is accepted and appears on the following cycle.
- Async reset mid-hazard:
  - Drop resetn between clock edges during BUBBLE.
  - Expect e_valid=0 and bubble_cnt=0 immediately, without waiting for a clock edge; d_ready=1 after release.
